// File: rtl/router_pkg.sv
// Shared router types: arbitration FSM states used by output-port allocators
// and VC-plane schedulers.
package router_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first set match bit found when
// searching from i_ptr upward, wrapping modulo N.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_match,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_winner,
  output logic          o_any
);

  logic [SW-1:0] w_idx;

  // Scan from the farthest offset down so the closest hit to i_ptr is kept last.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = SW'((int'(i_ptr) + k) % N);
      if (i_match[w_idx]) begin
        o_winner = w_idx;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_reservation_arbiter.sv
// Per-output-port allocator: round-robin grant of one output to one input port,
// held for a whole packet until the owner's relieve pulse.
module route_reservation_arbiter
  import router_pkg::*;
#(
  parameter  int N             = 4,
  parameter  int INDEX         = 0,
  parameter  int REQUEST_WIDTH = 2,
  parameter  int HOLD_WIDTH    = 8,
  localparam int SW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               routeReserveRequestValid,
  input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [N-1:0]               routeRelieve,
  output logic [N-1:0]               routeReserveStatus,
  output logic [SW-1:0]              sel,
  output logic                       sel_valid,
  output logic [HOLD_WIDTH-1:0]      hold_cycles
);

  arb_state_t            r_state;
  logic [SW-1:0]         r_owner;
  logic [SW-1:0]         r_ptr;
  logic [N-1:0]          r_status;
  logic [SW-1:0]         r_sel;
  logic                  r_selValid;
  logic [HOLD_WIDTH-1:0] r_hold;

  logic [N-1:0]          w_match;
  logic [SW-1:0]         w_winner;
  logic                  w_any;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < N; i++) begin
      w_match[i] = routeReserveRequestValid[i] &&
                   (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(INDEX));
    end
  end

  rr_priority_picker #(
    .N  (N),
    .SW (SW)
  ) u_picker (
    .i_match  (w_match),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Requests are only sampled in IDLE; during GRANT the owner keeps the output
  // regardless of its valid/request field until its own relieve arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_status   <= '0;
      r_sel      <= '0;
      r_selValid <= 1'b0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= GRANT;
            r_owner    <= w_winner;
            r_sel      <= w_winner;
            r_status   <= {{(N-1){1'b0}}, 1'b1} << w_winner;
            r_selValid <= 1'b1;
            r_hold     <= '0;
          end
        end
        GRANT: begin
          if (routeRelieve[r_owner]) begin
            r_state    <= IDLE;
            r_status   <= '0;
            r_selValid <= 1'b0;
            r_hold     <= '0;
            r_ptr      <= (r_owner == SW'(N - 1)) ? '0 : r_owner + SW'(1);
          end else if (r_hold != '1) begin
            r_hold <= r_hold + HOLD_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign routeReserveStatus = r_status;
  assign sel                = r_sel;
  assign sel_valid          = r_selValid;
  assign hold_cycles        = r_hold;

endmodule

// File: tb/tb_route_reservation_arbiter.sv
// Directed self-checking bench for route_reservation_arbiter (N=4, INDEX=2,
// HOLD_WIDTH=3 so hold saturation is reachable quickly).
module tb_route_reservation_arbiter;

  localparam int N  = 4;
  localparam int RW = 2;
  localparam int HW = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  reqValid;
  logic [N*RW-1:0] reqField;
  logic [N-1:0]  relieve;
  logic [N-1:0]  status;
  logic [1:0]    sel;
  logic          selValid;
  logic [HW-1:0] holdCycles;

  int checkCount;
  int passCount;

  route_reservation_arbiter #(
    .N             (N),
    .INDEX         (2),
    .REQUEST_WIDTH (RW),
    .HOLD_WIDTH    (HW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .routeReserveRequestValid (reqValid),
    .routeReserveRequest      (reqField),
    .routeRelieve             (relieve),
    .routeReserveStatus       (status),
    .sel                      (sel),
    .sel_valid                (selValid),
    .hold_cycles              (holdCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*RW-1:0] f, input logic [N-1:0] r);
    reqValid = v;
    reqField = f;
    relieve  = r;
  endtask

  task automatic checkGrant(input string tag, input logic [N-1:0] expStatus, input logic [1:0] expSel, input logic expValid);
    checkOutput({tag, "_status"}, 32'(status), 32'(expStatus));
    if (expValid) checkOutput({tag, "_sel"}, 32'(sel), 32'(expSel));
    checkOutput({tag, "_selValid"}, 32'(selValid), 32'(expValid));
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b0;
    applyStimulus('0, '0, '0);
    tick(2);

    checkOutput("reset_status", 32'(status), 32'h0);
    checkOutput("reset_sel", 32'(sel), 32'h0);
    checkOutput("reset_selValid", 32'(selValid), 32'h0);
    checkOutput("reset_hold", 32'(holdCycles), 32'h0);
    rst = 1'b1;

    // Single request from port 1 targeting output 2.
    applyStimulus(4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, '0);
    tick(1);
    checkGrant("single_grant", 4'b0010, 2'd1, 1'b1);
    checkOutput("single_hold0", 32'(holdCycles), 32'h0);
    applyStimulus('0, '0, '0);
    tick(4);
    checkOutput("single_hold4", 32'(holdCycles), 32'h4);
    checkGrant("single_held", 4'b0010, 2'd1, 1'b1);
    applyStimulus('0, '0, 4'b0010);
    tick(1);
    checkGrant("single_release", 4'b0000, 2'd0, 1'b0);
    checkOutput("single_holdClr", 32'(holdCycles), 32'h0);

    // ptr is now 2: ports 0 and 3 contend, port 3 comes first in the search.
    applyStimulus(4'b1001, {2'd2, 2'd0, 2'd0, 2'd2}, '0);
    tick(1);
    checkGrant("ptr_after_release", 4'b1000, 2'd3, 1'b1);
    applyStimulus('0, '0, 4'b1000);
    tick(1);
    checkGrant("ptr_release3", 4'b0000, 2'd0, 1'b0);

    // Non-matching request and relieve while idle are both ignored.
    applyStimulus(4'b0001, {2'd0, 2'd0, 2'd0, 2'd3}, 4'b1111);
    for (int c = 0; c < 20; c++) begin
      tick(1);
      relieve = '0;
      checkOutput($sformatf("nomatch_c%0d", c), 32'(status), 32'h0);
    end
    checkOutput("nomatch_selValid", 32'(selValid), 32'h0);

    // Round-robin: ptr=0, all ports request; each relieves 3 cycles after grant.
    applyStimulus(4'b1111, {2'd2, 2'd2, 2'd2, 2'd2}, '0);
    for (int g = 0; g < 5; g++) begin
      tick(1);
      checkGrant($sformatf("rr_grant%0d", g), 4'(1 << (g % N)), 2'(g % N), 1'b1);
      tick(2);
      relieve = 4'(1 << (g % N));
      tick(1);
      relieve = '0;
      checkGrant($sformatf("rr_gap%0d", g), 4'b0000, 2'd0, 1'b0);
    end
    applyStimulus('0, '0, '0);
    tick(1);

    // Foreign relieve, wormhole hold and saturation with port 2 owning (ptr=1).
    applyStimulus(4'b0100, {2'd0, 2'd2, 2'd0, 2'd0}, '0);
    tick(1);
    checkGrant("foreign_grant", 4'b0100, 2'd2, 1'b1);
    applyStimulus(4'b0000, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b1001);
    tick(1);
    relieve = '0;
    checkGrant("foreign_ignored", 4'b0100, 2'd2, 1'b1);
    checkOutput("foreign_hold1", 32'(holdCycles), 32'h1);
    tick(1);
    checkOutput("foreign_hold2", 32'(holdCycles), 32'h2);
    tick(10);
    checkOutput("sat_hold", 32'(holdCycles), 32'h7);
    checkGrant("sat_kept", 4'b0100, 2'd2, 1'b1);
    relieve = 4'b0100;
    tick(1);
    relieve = '0;
    checkGrant("sat_release", 4'b0000, 2'd0, 1'b0);
    checkOutput("sat_holdClr", 32'(holdCycles), 32'h0);

    // Async reset mid-grant: port 3 owns (ptr=3).
    applyStimulus(4'b1000, {2'd2, 2'd0, 2'd0, 2'd0}, '0);
    tick(1);
    checkGrant("areset_grant", 4'b1000, 2'd3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("areset_status", 32'(status), 32'h0);
    checkOutput("areset_selValid", 32'(selValid), 32'h0);
    checkOutput("areset_hold", 32'(holdCycles), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    checkGrant("areset_regrant", 4'b1000, 2'd3, 1'b1);
    applyStimulus('0, '0, 4'b1000);
    tick(1);
    relieve = '0;

    // ptr=0 after port 3 releases: ports 1 and 3 contend, port 1 wins.
    applyStimulus(4'b1010, {2'd2, 2'd0, 2'd2, 2'd0}, '0);
    tick(1);
    checkGrant("ptr_wrap", 4'b0010, 2'd1, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/route_reservation_arbiter.md
Name: route_reservation_arbiter

Overview:
- Per-output-port allocator for the router switch.
- Collects route reservation requests from N input ports and grants the output to one port at a time, using round-robin priority.
- Holds the grant for the whole packet until that port's relieve pulse arrives.
- Drives each port's reservation status and the crossbar select for its output.

Parameters:
- N, 4, number of input ports competing for this output.
- INDEX, 0, index of the output this arbiter owns; a request targets this output when its request field equals INDEX.
- REQUEST_WIDTH, 2, width of each port's request field; must satisfy 2**REQUEST_WIDTH >= N.
- HOLD_WIDTH, 8, width of the saturating grant-hold cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- routeReserveRequestValid  in  N  per-port request valid.
- routeReserveRequest  in  N*REQUEST_WIDTH  per-port requested output index; port i occupies bits [i*REQUEST_WIDTH +: REQUEST_WIDTH].
- routeRelieve  in  N  per-port single-cycle release pulse, sent on tail-flit handshake.
- routeReserveStatus  out  N  one-hot; bit i high while port i owns this output.
- sel  out  $clog2(N)  crossbar select, equal to the owner index.
- sel_valid  out  1  high while the output is owned.
- hold_cycles  out  HOLD_WIDTH  cycles the current owner has held the grant, saturating.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, routeReserveStatus=0, sel=0, sel_valid=0, hold_cycles=0.
  - Round-robin pointer ptr=0.
- Match vector: match[i] = routeReserveRequestValid[i] && (request field i == INDEX).
- State IDLE:
  - If match is nonzero, winner = first set bit of match searching i = ptr, ptr+1, ... mod N.
  - Register owner=winner and go to GRANT.
  - routeReserveStatus[owner]=1, sel=owner and sel_valid=1 from the next cycle. Request-to-status latency is exactly 1 cycle.
  - If match is zero, stay in IDLE; outputs stay 0 (sel holds its last value and is don't-care).
- State GRANT:
  - Outputs are held constant.
  - hold_cycles increments each cycle and saturates at 2**HOLD_WIDTH-1.
- Release: routeRelieve[owner]=1 while in GRANT causes, on the next edge:
  - state=IDLE, status=0, sel_valid=0, hold_cycles=0.
  - ptr = (owner+1) mod N.
- Relieve bits from non-owners are ignored in every state. Relieve while in IDLE is ignored.
- Owner dropping request valid, or changing its request field, during GRANT: grant is kept until relieve (wormhole semantics).
- Simultaneous relieve and other requests: relieve wins. The next arbitration happens in the IDLE cycle that follows, so there is at least one bubble cycle between owners.
- Same port relieving and re-requesting: it is lowest priority in the next arbitration (ptr has moved past it), so with other contenders it cannot win back-to-back.
- Fairness: with all N ports requesting continuously, grants rotate ptr, ptr+1, ... and no port waits more than N-1 grants.
- Reset asserted mid-GRANT: immediate return to IDLE with all outputs 0. The upstream port's FSM must re-request.
- Invariants:
  - routeReserveStatus is always zero or one-hot.
  - sel_valid == |routeReserveStatus.
  - Status goes high only for a port whose match bit was set in the arbitration cycle.

Decomposition:
- Shared package (router_pkg): arb_state_t enum {IDLE, GRANT}.
- Sub-module rr_priority_picker (combinational): inputs match[N] and ptr; outputs winner index and any. Reused by VC-plane schedulers.
- Top holds the FSM, owner/ptr registers and the hold counter.

Test Plan:
- Single request: N=4, INDEX=2; port 1 valid with req=2 at cycle 0 -> status=4'b0010, sel=1, sel_valid=1 at cycle 1; relieve[1] at cycle 5 -> status=0 at cycle 6, ptr=2.
- Non-matching request: port 0 valid with req=3 (INDEX=2) -> status stays 0 for 20 cycles.
- Round-robin: all 4 ports request continuously and each relieves 3 cycles after its grant -> grant order 0,1,2,3,0 with a 1-cycle IDLE gap between owners.
- Foreign relieve: port 2 owns; relieve[0] and relieve[3] pulse -> status stays 4'b0100; hold_cycles keeps counting.
- Saturation and deassert: HOLD_WIDTH=3; owner holds for 12 cycles with request valid dropped after cycle 2 -> hold_cycles sticks at 7 and the grant is kept until relieve.
- Async reset mid-grant: rst driven low between clock edges while port 3 owns -> status=0 and sel_valid=0 immediately, without waiting for an edge; after rst releases, port 3 wins first arbitration (ptr=0, only requester).
